// File: rtl/avmm_pio_bank_pkg.sv
// Shared constants and types for the Avalon-MM PIO bank.
// Register regions are selected by word address bits [5:4].
package avmm_pio_bank_pkg;

    localparam logic [1:0] OFS_OUT  = 2'd0;
    localparam logic [1:0] OFS_IN   = 2'd1;
    localparam logic [1:0] OFS_EDGE = 2'd2;
    localparam logic [1:0] OFS_MASK = 2'd3;

    typedef enum logic [1:0] {
        EdgeRise = 2'd0,
        EdgeFall = 2'd1,
        EdgeAny  = 2'd2
    } edge_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while (res < 32 && (64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/pio_in_channel.sv
// One input channel: synchroniser, optional debounce (PIO_DEBOUNCE_EN),
// prime flag, edge detect and the sticky EDGE_CAP register with W1C.
module pio_in_channel
    import avmm_pio_bank_pkg::*;
#(
    parameter int unsigned DataW          = 32,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned EdgeMode       = 0,
    parameter int unsigned DebounceCycles = 50000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [DataW-1:0] in_i,
    input  logic [DataW-1:0] w1c_i,
    output logic [DataW-1:0] cond_o,
    output logic [DataW-1:0] edge_cap_o
);

    localparam edge_mode_e Mode = edge_mode_e'(EdgeMode[1:0]);

    logic [DataW-1:0]      sync_q [SyncStages];
    logic [SyncStages-1:0] sync_vld_q;
    logic [DataW-1:0]      sync_val;
    logic                  sync_vld;
    logic [DataW-1:0]      cond;
    logic                  cond_vld;
    logic [DataW-1:0]      cond_prev_q;
    logic [DataW-1:0]      edge_cap_q;
    logic [DataW-1:0]      edge_cap_d;
    logic [DataW-1:0]      edge_hit;
    logic                  primed_q;

    // sync_vld_q marks stages that hold real post-reset samples.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                sync_q[i] <= '0;
            end
            sync_vld_q <= '0;
        end else begin
            sync_q[0] <= in_i;
            for (int i = 1; i < int'(SyncStages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_vld_q <= {sync_vld_q[SyncStages-2:0], 1'b1};
        end
    end

    assign sync_val = sync_q[SyncStages-1];
    assign sync_vld = sync_vld_q[SyncStages-1];

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned CntRaw = clog2(DebounceCycles + 1);
    localparam int unsigned CntW   = (CntRaw < 16) ? 16 : CntRaw;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [CntW-1:0]  cnt_q;
    logic [DataW-1:0] cand_q;
    logic [DataW-1:0] cond_q;
    logic             loaded_q;

    // The first valid sample is taken as already settled; later changes must
    // hold for the full window before they reach cond.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            cand_q   <= '0;
            cond_q   <= '0;
            loaded_q <= 1'b0;
        end else if (sync_vld) begin
            if (!loaded_q) begin
                cond_q   <= sync_val;
                cand_q   <= sync_val;
                cnt_q    <= CntLast;
                loaded_q <= 1'b1;
            end else if (sync_val != cand_q) begin
                cand_q <= sync_val;
                cnt_q  <= CntW'(1);
            end else if (cnt_q >= CntLast) begin
                cond_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cond     = cond_q;
    assign cond_vld = loaded_q;
`else
    assign cond     = sync_val;
    assign cond_vld = sync_vld;
`endif

    always_comb begin
        edge_hit = '0;
        case (Mode)
            EdgeRise: edge_hit = cond & ~cond_prev_q;
            EdgeFall: edge_hit = ~cond & cond_prev_q;
            default:  edge_hit = cond ^ cond_prev_q;
        endcase
        if (!primed_q) begin
            edge_hit = '0;
        end
        // A set in the same cycle as a W1C of the same bit wins.
        edge_cap_d = (edge_cap_q & ~w1c_i) | edge_hit;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cond_prev_q <= '0;
            edge_cap_q  <= '0;
            primed_q    <= 1'b0;
        end else begin
            cond_prev_q <= cond;
            edge_cap_q  <= edge_cap_d;
            primed_q    <= primed_q | cond_vld;
        end
    end

    assign cond_o     = cond;
    assign edge_cap_o = edge_cap_q;

endmodule

// File: rtl/avmm_pio_bank.sv
// Parametrised Avalon-MM PIO bank: OUT_DATA, IN_DATA, EDGE_CAP and IRQ_MASK per channel.
// Define PIO_DEBOUNCE_EN to add a per-channel input stability filter.
module avmm_pio_bank
    import avmm_pio_bank_pkg::*;
#(
    parameter int unsigned NUM_OUT         = 4,
    parameter int unsigned NUM_IN          = 4,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_MODE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                avs_address,
    input  logic                      avs_read,
    input  logic                      avs_write,
    input  logic [DATA_W-1:0]         avs_writedata,
    input  logic [DATA_W/8-1:0]       avs_byteenable,
    output logic [DATA_W-1:0]         avs_readdata,
    output logic                      avs_readdatavalid,
    output logic [NUM_OUT*DATA_W-1:0] out_export,
    input  logic [NUM_IN*DATA_W-1:0]  in_export,
    output logic                      irq
);

    localparam int unsigned BeW = DATA_W / 8;

    logic [1:0]        region;
    logic [3:0]        ch;
    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] wr_masked;
    logic [DATA_W-1:0] out_q   [NUM_OUT];
    logic [DATA_W-1:0] mask_q  [NUM_IN];
    logic [DATA_W-1:0] in_cond [NUM_IN];
    logic [DATA_W-1:0] in_cap  [NUM_IN];
    logic [DATA_W-1:0] w1c     [NUM_IN];
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] readdata_q;
    logic              readdatavalid_q;
    logic              irq_d;
    logic              irq_q;

    assign region = avs_address[5:4];
    assign ch     = avs_address[3:0];

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < int'(BeW); b++) begin
            be_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
        end
        wr_masked = avs_writedata & be_mask;
    end

    for (genvar g = 0; g < int'(NUM_IN); g++) begin : g_in
        assign w1c[g] = (avs_write && region == OFS_EDGE && ch == 4'(g)) ? wr_masked : '0;

        pio_in_channel #(
            .DataW          (DATA_W),
            .SyncStages     (SYNC_STAGES),
            .EdgeMode       (EDGE_MODE),
            .DebounceCycles (DEBOUNCE_CYCLES)
        ) u_in_channel (
            .clk_i      (clk),
            .reset_i    (reset),
            .in_i       (in_export[g*DATA_W +: DATA_W]),
            .w1c_i      (w1c[g]),
            .cond_o     (in_cond[g]),
            .edge_cap_o (in_cap[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                out_q[i] <= '0;
            end
        end else if (avs_write && region == OFS_OUT) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (ch == 4'(i)) begin
                    out_q[i] <= (out_q[i] & ~be_mask) | wr_masked;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                mask_q[i] <= '0;
            end
        end else if (avs_write && region == OFS_MASK) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (ch == 4'(i)) begin
                    mask_q[i] <= (mask_q[i] & ~be_mask) | wr_masked;
                end
            end
        end
    end

    // Channels beyond NUM_OUT/NUM_IN fall through and read as zero.
    always_comb begin
        rd_val = '0;
        unique case (region)
            OFS_OUT: begin
                for (int i = 0; i < int'(NUM_OUT); i++) begin
                    if (ch == 4'(i)) rd_val = out_q[i];
                end
            end
            OFS_IN: begin
                for (int i = 0; i < int'(NUM_IN); i++) begin
                    if (ch == 4'(i)) rd_val = in_cond[i];
                end
            end
            OFS_EDGE: begin
                for (int i = 0; i < int'(NUM_IN); i++) begin
                    if (ch == 4'(i)) rd_val = in_cap[i];
                end
            end
            OFS_MASK: begin
                for (int i = 0; i < int'(NUM_IN); i++) begin
                    if (ch == 4'(i)) rd_val = mask_q[i];
                end
            end
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            irq_d = irq_d | (|(in_cap[i] & mask_q[i]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            readdata_q      <= avs_read ? rd_val : '0;
            readdatavalid_q <= avs_read;
            irq_q           <= irq_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_out
        assign out_export[g*DATA_W +: DATA_W] = out_q[g];
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_avmm_pio_bank.sv
// Bench for avmm_pio_bank: per-cycle compare against a history-based register model,
// plus directed literal checks.
module tb_avmm_pio_bank;

    localparam int NO = 4;
    localparam int NI = 4;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int DB = 8;
`ifdef PIO_DEBOUNCE_EN
    localparam bit ModelIn = 1'b0;
`else
    localparam bit ModelIn = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic [127:0]  out_export;
    logic [127:0]  in_export;
    logic          irq;

    int nvec = 0;
    int nerr = 0;

    avmm_pio_bank #(
        .NUM_OUT         (NO),
        .NUM_IN          (NI),
        .DATA_W          (W),
        .SYNC_STAGES     (S),
        .EDGE_MODE       (0),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .out_export        (out_export),
        .in_export         (in_export),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: registers as arrays, inputs as a sample history since reset release.
    logic [31:0]  m_out [NO];
    logic [31:0]  m_mask [NI];
    logic [31:0]  m_cap [NI];
    logic         m_irq;
    logic         m_rdv;
    logic [31:0]  m_rd;
    logic         m_rd_ok;
    logic [127:0] hist [$];
    int           n;

    always @(posedge clk or posedge reset) begin
        logic [31:0] bm;
        logic [31:0] cur [NI];
        logic [31:0] setb [NI];
        logic [1:0]  rg;
        int          c;
        if (reset) begin
            for (int i = 0; i < NO; i++) m_out[i] = '0;
            for (int i = 0; i < NI; i++) begin
                m_mask[i] = '0;
                m_cap[i]  = '0;
            end
            m_irq = 0; m_rdv = 0; m_rd = '0; m_rd_ok = 1;
            hist.delete();
            n = 0;
        end else begin
            for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{avs_byteenable[b]}};
            for (int i = 0; i < NI; i++) cur[i] = (n >= S) ? hist[S-1][i*32 +: 32] : 32'h0;
            rg = avs_address[5:4];
            c  = int'(avs_address[3:0]);
            m_rdv = avs_read;
            m_rd = '0;
            m_rd_ok = 1'b1;
            if (avs_read && c < 4) begin
                case (rg)
                    2'd0: m_rd = m_out[c];
                    2'd1: begin m_rd = cur[c]; m_rd_ok = ModelIn; end
                    2'd2: begin m_rd = m_cap[c]; m_rd_ok = ModelIn; end
                    default: m_rd = m_mask[c];
                endcase
            end
            m_irq = 1'b0;
            for (int i = 0; i < NI; i++) m_irq = m_irq | (|(m_cap[i] & m_mask[i]));
            hist.push_front(in_export);
            n++;
            if (hist.size() > S + 2) void'(hist.pop_back());
            for (int i = 0; i < NI; i++)
                setb[i] = (n >= S + 2) ? (hist[S][i*32 +: 32] & ~hist[S+1][i*32 +: 32]) : 32'h0;
            for (int i = 0; i < NI; i++) begin
                logic [31:0] clr;
                clr = (avs_write && rg == 2'd2 && c == i) ? (avs_writedata & bm) : 32'h0;
                m_cap[i] = (m_cap[i] & ~clr) | setb[i];
                if (avs_write && rg == 2'd3 && c == i)
                    m_mask[i] = (m_mask[i] & ~bm) | (avs_writedata & bm);
            end
            if (avs_write && rg == 2'd0 && c < NO)
                m_out[c] = (m_out[c] & ~bm) | (avs_writedata & bm);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("out_export", out_export, {m_out[3], m_out[2], m_out[1], m_out[0]});
            chk("readdatavalid", 128'(avs_readdatavalid), 128'(m_rdv));
            if (m_rdv && m_rd_ok) chk("readdata", 128'(avs_readdata), 128'(m_rd));
`ifndef PIO_DEBOUNCE_EN
            chk("irq", 128'(irq), 128'(m_irq));
`endif
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        chk("rd_valid", 128'(avs_readdatavalid), 128'(1));
        d = avs_readdata;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1; avs_address = '0; avs_read = 0; avs_write = 0;
        avs_writedata = '0; avs_byteenable = '0; in_export = '0;
        cyc(3);
        reset = 1'b0;

        // Reset state over the whole map.
        chk("reset_irq", 128'(irq), 128'(0));
        chk("reset_out", out_export, 128'(0));
        for (int a = 0; a < 64; a++) begin
            rd(6'(a), d);
            chk("reset_read", 128'(d), 128'(0));
        end

        // Byte-enabled write, one-cycle valid pulse.
        wr(6'h01, 32'h12345678, 4'b0011);
        chk("out_ch1", 128'(out_export[63:32]), 128'(32'h00005678));
        rd(6'h01, d);
        chk("rd_out_ch1", 128'(d), 128'(32'h00005678));
        cyc(1);
        chk("rdv_one_cycle", 128'(avs_readdatavalid), 128'(0));

        // Same-cycle read and write returns the old value.
        avs_writedata = 32'hAABBCCDD; avs_byteenable = 4'hF; avs_write = 1'b1;
        rd(6'h01, d);
        avs_write = 1'b0;
        chk("rw_same_cycle", 128'(d), 128'(32'h00005678));
        rd(6'h01, d);
        chk("rd_after_rw", 128'(d), 128'(32'hAABBCCDD));

        // Unmapped channel and region writes are dropped.
        wr(6'h05, 32'hFFFFFFFF, 4'hF);
        rd(6'h05, d);
        chk("unmapped_ch", 128'(d), 128'(0));

        // Rising edge on ch0 bit0: capture after 3 cycles, irq one later.
        wr(6'h30, 32'h1, 4'hF);
        in_export[0] = 1'b1;
        cyc(3);
        chk("irq_not_yet", 128'(irq), 128'(0));
        cyc(1);
        chk("irq_set", 128'(irq), 128'(1));
        rd(6'h20, d);
        chk("edge_cap_ch0", 128'(d), 128'(1));
        wr(6'h20, 32'h1, 4'hF);
        cyc(1);
        chk("irq_cleared", 128'(irq), 128'(0));

        // Falling edge is ignored in rising mode.
        in_export[0] = 1'b0;
        cyc(5);
        rd(6'h20, d);
        chk("fall_ignored", 128'(d), 128'(0));

        // Set beats a simultaneous W1C.
        in_export[0] = 1'b1;
        cyc(2);
        wr(6'h20, 32'h1, 4'hF);
        rd(6'h20, d);
        chk("set_wins", 128'(d), 128'(1));
        wr(6'h20, 32'h1, 4'hF);

        // Reset mid-read: no valid, state cleared; ch1 held high across reset.
        in_export[63:32] = 32'h0000FFFF;
        avs_address = 6'h01; avs_read = 1'b1;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        chk("reset_drop_rdv", 128'(avs_readdatavalid), 128'(0));
        chk("reset_out_clr", out_export, 128'(0));
        chk("reset_irq_clr", 128'(irq), 128'(0));
        cyc(2);
        reset = 1'b0;
        wr(6'h31, 32'h0000FFFF, 4'hF);
        cyc(6);
        rd(6'h11, d);
        chk("held_in_data", 128'(d), 128'(32'h0000FFFF));
        rd(6'h21, d);
        chk("held_no_edge", 128'(d), 128'(0));
        chk("held_no_irq", 128'(irq), 128'(0));

        // Multi-bit edges on ch1 and byte-enabled W1C.
        in_export[63:32] = 32'h000000FF;
        cyc(15);
        in_export[63:32] = 32'h0000FFFF;
        cyc(15);
        rd(6'h21, d);
        chk("multi_edge", 128'(d), 128'(32'h0000FF00));
        chk("multi_irq", 128'(irq), 128'(1));
        wr(6'h21, 32'hFFFFFFFF, 4'b0001);
        rd(6'h21, d);
        chk("w1c_wrong_lane", 128'(d), 128'(32'h0000FF00));
        wr(6'h21, 32'hFFFFFFFF, 4'b0010);
        rd(6'h21, d);
        chk("w1c_lane1", 128'(d), 128'(0));
        cyc(1);
        chk("irq_after_w1c", 128'(irq), 128'(0));

`ifdef PIO_DEBOUNCE_EN
        // Short pulse is filtered; held level appears after SYNC_STAGES+DB cycles.
        in_export[95:64] = 32'h1;
        cyc(5);
        in_export[95:64] = 32'h0;
        cyc(20);
        rd(6'h12, d);
        chk("db_glitch", 128'(d), 128'(0));
        in_export[95:64] = 32'h3;
        cyc(S + DB - 1);
        rd(6'h12, d);
        chk("db_early", 128'(d), 128'(0));
        rd(6'h12, d);
        chk("db_settled", 128'(d), 128'(3));
`endif

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
